div_ctrl: RTL

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_if.sv | 37 +++
 rtl/div_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/div_ctrl_if.sv
// Handshake and data bundle between the execute stage, the iterative
// divider and the write-back path of the divide controller.
interface div_ctrl_if;
    logic        valid_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        div_start_o;
    logic        div_signed_o;
    logic        annul_o;
    logic [31:0] dividend_o;
    logic [31:0] divisor_o;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        stall_o;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_addr_o;

    // Pipeline / divider side: drives requests and divider responses
    modport master (
        output valid_i, op_i, rs1_i, rs2_i, rd_addr_i, flush_i,
        output div_ready_i, div_result_i,
        input  div_start_o, div_signed_o, annul_o, dividend_o, divisor_o,
        input  stall_o, wb_valid_o, wb_data_o, wb_addr_o
    );

    // Controller side
    modport slave (
        input  valid_i, op_i, rs1_i, rs2_i, rd_addr_i, flush_i,
        input  div_ready_i, div_result_i,
        output div_start_o, div_signed_o, annul_o, dividend_o, divisor_o,
        output stall_o, wb_valid_o, wb_data_o, wb_addr_o
    );
endinterface

// File: rtl/div_ctrl.sv
// Divide-class instruction controller: accepts DIV/DIVU/REM/REMU from EX,
// resolves divide-by-zero and signed overflow locally, otherwise drives an
// external iterative divider and returns the selected half of its result
// to write-back. A DRAIN state waits for the divider to go idle before the
// next accept.
module div_ctrl (
    input  logic       ck_i,
    input  logic       rs_i,
    div_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPEC  = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic        is_rem_reg;
    logic [4:0]  rd_reg;
    logic [31:0] dividend_reg, divisor_reg, wb_data_reg;
    logic        div_start_reg, div_signed_reg;

    logic        accept;
    logic        op_signed, op_rem;
    logic        div_by_zero, signed_ovf, special;
    logic [31:0] special_result;

    // Decode the incoming operation and its special cases
    always_comb begin
        op_signed      = ~bus.op_i[0];
        op_rem         = bus.op_i[1];
        div_by_zero    = (bus.rs2_i == 32'd0);
        signed_ovf     = op_signed && (bus.rs1_i == 32'h8000_0000) &&
                         (bus.rs2_i == 32'hFFFF_FFFF);
        special        = div_by_zero || signed_ovf;
        // Zero divisor wins over overflow (overflow needs divisor = -1 anyway)
        if (div_by_zero)
            special_result = op_rem ? bus.rs1_i : 32'hFFFF_FFFF;
        else
            special_result = op_rem ? 32'd0 : 32'h8000_0000;
        // The divider must be idle (ready low) before a new accept
        accept         = (state_reg == IDLE) && bus.valid_i &&
                         !bus.flush_i && !bus.div_ready_i;
    end

    // State register
    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic and combinational outputs
    always_comb begin
        state_next     = state_reg;
        bus.stall_o    = 1'b0;
        bus.annul_o    = 1'b0;
        bus.wb_valid_o = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.stall_o = accept;
                if (accept)
                    state_next = special ? SPEC : WAIT;
            end
            SPEC: begin
                bus.wb_valid_o = 1'b1;
                state_next     = DRAIN;
            end
            WAIT: begin
                bus.stall_o = 1'b1;
                // Flush beats a simultaneous ready: the result is dropped
                if (bus.flush_i) begin
                    bus.annul_o = 1'b1;
                    state_next  = DRAIN;
                end else if (bus.div_ready_i) begin
                    state_next  = DONE;
                end
            end
            DONE: begin
                bus.wb_valid_o = 1'b1;
                state_next     = DRAIN;
            end
            DRAIN: begin
                bus.stall_o = bus.valid_i;
                if (!bus.div_ready_i)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latching, divider control and result capture
    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i) begin
            is_rem_reg     <= 1'b0;
            rd_reg         <= 5'd0;
            dividend_reg   <= 32'd0;
            divisor_reg    <= 32'd0;
            wb_data_reg    <= 32'd0;
            div_start_reg  <= 1'b0;
            div_signed_reg <= 1'b0;
        end else begin
            if (accept) begin
                is_rem_reg   <= op_rem;
                rd_reg       <= bus.rd_addr_i;
                dividend_reg <= bus.rs1_i;
                divisor_reg  <= bus.rs2_i;
                if (special) begin
                    wb_data_reg <= special_result;
                end else begin
                    div_start_reg  <= 1'b1;
                    div_signed_reg <= op_signed;
                end
            end
            if (state_reg == WAIT) begin
                if (bus.flush_i) begin
                    div_start_reg <= 1'b0;
                end else if (bus.div_ready_i) begin
                    div_start_reg <= 1'b0;
                    wb_data_reg   <= is_rem_reg ? bus.div_result_i[63:32]
                                                : bus.div_result_i[31:0];
                end
            end
        end
    end

    assign bus.div_start_o  = div_start_reg;
    assign bus.div_signed_o = div_signed_reg;
    assign bus.dividend_o   = dividend_reg;
    assign bus.divisor_o    = divisor_reg;
    assign bus.wb_data_o    = wb_data_reg;
    assign bus.wb_addr_o    = rd_reg;
endmodule
